// File: rtl/conversor_comp2_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : conversor_comp2_pkg
//  Brief    : Mode encodings and default width for the two's-complement
//             conversion unit.
//  Revision : 1.0 - initial release
// ============================================================================
package conversor_comp2_pkg;

    localparam int DEFAULT_WIDTH = 6;

    localparam logic [1:0] MODE_NEG  = 2'b00;
    localparam logic [1:0] MODE_PASS = 2'b01;
    localparam logic [1:0] MODE_ABS  = 2'b10;
    localparam logic [1:0] MODE_SM   = 2'b11;

endpackage : conversor_comp2_pkg
`default_nettype wire

// File: rtl/comp2_negate.sv
`default_nettype none
// ============================================================================
//  Module   : comp2_negate
//  Brief    : Combinational two's-complement negation (~x + 1) with a flag
//             for the most-negative value, which has no positive counterpart.
//  Revision : 1.0 - initial release
// ============================================================================
module comp2_negate #(
    parameter int WIDTH = 6
) (
    input  logic [WIDTH-1:0] i_x,
    output logic [WIDTH-1:0] o_y,
    output logic             o_ovf
);

    localparam logic [WIDTH-1:0] c_MIN = {1'b1, {(WIDTH-1){1'b0}}};

    assign o_y   = ~i_x + {{(WIDTH-1){1'b0}}, 1'b1};
    assign o_ovf = (i_x == c_MIN);

endmodule : comp2_negate
`default_nettype wire

// File: rtl/conversor_comp2.sv
`default_nettype none
// ============================================================================
//  Module   : conversor_comp2
//  Brief    : Registered two's-complement conversion unit (negate, pass,
//             absolute value, sign-magnitude to two's complement) with
//             overflow/zero/negative flags. Optional macro COMP2_SAT_EN
//             saturates overflowing results to the largest positive value.
//  Revision : 1.0 - initial release
// ============================================================================
module conversor_comp2
    import conversor_comp2_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] A,
    output logic             out_valid,
    output logic [WIDTH-1:0] A_convertido,
    output logic             ovf,
    output logic             zero,
    output logic             neg
);

`ifdef COMP2_SAT_EN
    localparam logic [WIDTH-1:0] c_SAT_MAX = {1'b0, {(WIDTH-1){1'b1}}};
`endif

    logic [WIDTH-1:0] w_mag;
    logic [WIDTH-1:0] w_neg_in;
    logic [WIDTH-1:0] w_neg_out;
    logic             w_neg_ovf;
    logic [WIDTH-1:0] w_res;
    logic             w_ovf;

    logic             r_out_valid;
    logic [WIDTH-1:0] r_res;
    logic             r_ovf;
    logic             r_zero;
    logic             r_neg;

    // Sign-magnitude mode shares the single negator with its zero-extended
    // magnitude; the magnitude can never be the most-negative value.
    assign w_mag    = {1'b0, A[WIDTH-2:0]};
    assign w_neg_in = (mode == MODE_SM) ? w_mag : A;

    comp2_negate #(
        .WIDTH (WIDTH)
    ) u_negate (
        .i_x   (w_neg_in),
        .o_y   (w_neg_out),
        .o_ovf (w_neg_ovf)
    );

    always_comb begin
        w_res = A;
        w_ovf = 1'b0;
        case (mode)
            MODE_NEG: begin
                w_res = w_neg_out;
                w_ovf = w_neg_ovf;
            end
            MODE_PASS: begin
                w_res = A;
                w_ovf = 1'b0;
            end
            MODE_ABS: begin
                w_res = A[WIDTH-1] ? w_neg_out : A;
                w_ovf = w_neg_ovf;
            end
            MODE_SM: begin
                w_res = A[WIDTH-1] ? w_neg_out : w_mag;
                w_ovf = 1'b0;
            end
            default: begin
                w_res = A;
                w_ovf = 1'b0;
            end
        endcase
`ifdef COMP2_SAT_EN
        if (w_ovf) begin
            w_res = c_SAT_MAX;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            r_res       <= '0;
            r_ovf       <= 1'b0;
            r_zero      <= 1'b0;
            r_neg       <= 1'b0;
        end else begin
            r_out_valid <= in_valid;
            if (in_valid) begin
                r_res  <= w_res;
                r_ovf  <= w_ovf;
                r_zero <= (w_res == '0);
                r_neg  <= w_res[WIDTH-1];
            end
        end
    end

    assign out_valid    = r_out_valid;
    assign A_convertido = r_res;
    assign ovf          = r_ovf;
    assign zero         = r_zero;
    assign neg          = r_neg;

endmodule : conversor_comp2
`default_nettype wire

// File: tb/tb_conversor_comp2.sv
`default_nettype none
// ============================================================================
//  Module   : tb_conversor_comp2
//  Brief    : Directed self-checking bench for conversor_comp2 (WIDTH=6).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_conversor_comp2;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic [1:0] mode;
    logic [5:0] A;
    logic       out_valid;
    logic [5:0] A_convertido;
    logic       ovf;
    logic       zero;
    logic       neg;

    int tests  = 0;
    int failed = 0;

    conversor_comp2 #(.WIDTH(6)) dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .mode         (mode),
        .A            (A),
        .out_valid    (out_valid),
        .A_convertido (A_convertido),
        .ovf          (ovf),
        .zero         (zero),
        .neg          (neg)
    );

    always #5 clk = ~clk;

    // Apply inputs, then sample 1 time unit after the capturing edge.
    task automatic step(input logic r, input logic v, input logic [1:0] m, input logic [5:0] a);
        rst      = r;
        in_valid = v;
        mode     = m;
        A        = a;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [5:0] got, input logic [5:0] exp);
        tests++;
        assert (got === exp)
        else begin
            failed++;
            $error("FAIL %s: observed %b expected %b", tag, got, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic ev, input logic [5:0] er,
                           input logic eo, input logic ez, input logic en);
        chk({tag, ".valid"}, {5'b0, out_valid}, {5'b0, ev});
        chk({tag, ".R"},     A_convertido,      er);
        chk({tag, ".ovf"},   {5'b0, ovf},       {5'b0, eo});
        chk({tag, ".zero"},  {5'b0, zero},      {5'b0, ez});
        chk({tag, ".neg"},   {5'b0, neg},       {5'b0, en});
    endtask

    initial begin
        logic [5:0] e;
        logic [5:0] min_res;
`ifdef COMP2_SAT_EN
        min_res = 6'b011111;
`else
        min_res = 6'b100000;
`endif
        rst = 1'b1; in_valid = 1'b0; mode = 2'b00; A = '0;

        // Reset
        step(1'b1, 1'b0, 2'b00, 6'd0);
        step(1'b1, 1'b0, 2'b00, 6'd0);
        step(1'b0, 1'b0, 2'b00, 6'd0);
        chk_all("reset", 1'b0, 6'b000000, 1'b0, 1'b0, 1'b0);

        // Negate sweep over all 64 operands
        for (int a = 0; a < 64; a++) begin
            step(1'b0, 1'b1, 2'b00, 6'(a));
            e = 6'((64 - a) % 64);
            if (a == 32) e = min_res;
            chk_all($sformatf("neg[%0d]", a), 1'b1, e, (a == 32), (e == 6'd0), e[5]);
        end

        // Named boundary points of the negate mode
        step(1'b0, 1'b1, 2'b00, 6'b000001);
        chk_all("neg_one", 1'b1, 6'b111111, 1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b1, 2'b00, 6'b000000);
        chk_all("neg_zero", 1'b1, 6'b000000, 1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b1, 2'b00, 6'b100000);
        chk_all("neg_min", 1'b1, min_res, 1'b1, 1'b0, min_res[5]);

        // Absolute value
        step(1'b0, 1'b1, 2'b10, 6'b110110);
        chk_all("abs_m10", 1'b1, 6'b001010, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 2'b10, 6'b011111);
        chk_all("abs_max", 1'b1, 6'b011111, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 2'b10, 6'b100000);
        chk_all("abs_min", 1'b1, min_res, 1'b1, 1'b0, min_res[5]);
        step(1'b0, 1'b1, 2'b10, 6'b111111);
        chk_all("abs_m1", 1'b1, 6'b000001, 1'b0, 1'b0, 1'b0);

        // Sign-magnitude
        step(1'b0, 1'b1, 2'b11, 6'b100101);
        chk_all("sm_m5", 1'b1, 6'b111011, 1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b1, 2'b11, 6'b100000);
        chk_all("sm_negzero", 1'b1, 6'b000000, 1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b1, 2'b11, 6'b001101);
        chk_all("sm_p13", 1'b1, 6'b001101, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 2'b11, 6'b111111);
        chk_all("sm_m31", 1'b1, 6'b100001, 1'b0, 1'b0, 1'b1);

        // Pass and hold
        step(1'b0, 1'b1, 2'b01, 6'b010101);
        chk_all("pass", 1'b1, 6'b010101, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 2'b00, 6'b100000);
        chk_all("hold1", 1'b0, 6'b010101, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 2'b10, 6'b111111);
        chk_all("hold2", 1'b0, 6'b010101, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 2'b01, 6'b110000);
        chk_all("pass_neg", 1'b1, 6'b110000, 1'b0, 1'b0, 1'b1);

        // Reset wins over a simultaneous operand
        step(1'b1, 1'b1, 2'b00, 6'b000011);
        chk_all("rst_prio", 1'b0, 6'b000000, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 2'b00, 6'b000011);
        chk_all("post_rst", 1'b1, 6'b111101, 1'b0, 1'b0, 1'b1);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule : tb_conversor_comp2
`default_nettype wire
